// File: rtl/seg7_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package seg7_pkg;
    localparam int MAX_DIGITS = 8;

    typedef logic [15:0]                 cnt_t;
    typedef logic [2:0]                  idx_t;
    typedef logic [MAX_DIGITS-1:0][3:0]  nib_vec_t;
    typedef logic [MAX_DIGITS-1:0]       dp_vec_t;

    function automatic logic [MAX_DIGITS-1:0] onehot_sel(input idx_t idx, input logic active_low);
        logic [MAX_DIGITS-1:0] sel;
        sel      = '0;
        sel[idx] = 1'b1;
        return active_low ? ~sel : sel;
    endfunction
endpackage

// File: rtl/seg7_tick_gen.sv
// Digit-slot prescaler: counts while enabled and pulses tick on the last cycle of a slot.
// With SEG7_SCAN_BLANK_EN defined, blank flags that last cycle so the strobe can be suppressed.
module seg7_tick_gen
    import seg7_pkg::*;
#(
    parameter int PRESCALE = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    output logic tick,
    output logic blank
);
    cnt_t count;
    logic slot_end;

    assign slot_end = (count == cnt_t'(PRESCALE - 1));
    assign tick     = slot_end && ena;

`ifdef SEG7_SCAN_BLANK_EN
    assign blank = slot_end;
`else
    assign blank = 1'b0;
`endif

    // Count holds while disabled so the scan resumes mid-slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (tick)
            count <= '0;
        else if (ena)
            count <= count + 16'd1;
    end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with frame-aligned load/ack value updates.
// Optional inter-digit blanking is enabled by defining SEG7_SCAN_BLANK_EN.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int PRESCALE       = 1000,
    parameter bit SEL_ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    load_i,
    output logic                    load_ack_o,
    output logic                    pending_o,
    output logic [3:0]              bin_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   digit_sel_o,
    output logic                    frame_o
);
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_ACTIVE_LOW}};

    logic                  tick, blank, boundary, sel_on;
    logic [MAX_DIGITS-1:0] sel_full;
    logic [NUM_DIGITS-1:0] sel_next;
    idx_t                  idx;
    nib_vec_t              disp_nib, pend_nib;
    dp_vec_t               disp_dp, pend_dp;
    logic                  pending;

    seg7_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .tick  (tick),
        .blank (blank)
    );

    assign boundary  = tick && (idx == idx_t'(NUM_DIGITS - 1));
    assign pending_o = pending;

    always_comb begin
        sel_on   = ena && !blank;
        sel_full = onehot_sel(idx, SEL_ACTIVE_LOW);
        sel_next = sel_on ? sel_full[NUM_DIGITS-1:0] : SEL_OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            disp_nib    <= '0;
            disp_dp     <= '0;
            pend_nib    <= '0;
            pend_dp     <= '0;
            pending     <= 1'b0;
            bin_o       <= '0;
            dp_o        <= 1'b0;
            digit_sel_o <= SEL_OFF;
            frame_o     <= 1'b0;
            load_ack_o  <= 1'b0;
        end else begin
            if (tick)
                idx <= (idx == idx_t'(NUM_DIGITS - 1)) ? '0 : idx + 3'd1;

            // The old pending value is applied even when a new load lands on the boundary.
            if (boundary && pending) begin
                disp_nib <= pend_nib;
                disp_dp  <= pend_dp;
            end

            if (load_i) begin
                pend_nib <= nib_vec_t'(value_i);
                pend_dp  <= dp_vec_t'(dp_i);
                pending  <= 1'b1;
            end else if (boundary) begin
                pending  <= 1'b0;
            end

            bin_o       <= disp_nib[idx];
            dp_o        <= disp_dp[idx];
            digit_sel_o <= sel_next;
            frame_o     <= boundary;
            load_ack_o  <= boundary && pending;
        end
    end
endmodule
